sar_logic: RTL
==============

// Module: sar_logic
// PURPOSE
//  Successive-approximation controller for the SAR-ADC model. It sits directly downstream of
//  the sample-and-hold stage. It drives the S/H track/hold control ('sample'), then runs an
//  NBIT binary search on the capacitive-DAC code using the comparator decision. It presents
//  the final code on dout together with a one-cycle valid strobe.
// PARAMETERS
//  NBIT        8   resolution in bits; legal range NBIT >= 2
//  SAMPLE_CYC  2   number of clk cycles the S/H tracks (sample=1) per conversion; >= 1
// PORTS
//  clk       input   1     conversion clock; all state updates on posedge
//  rst       input   1     synchronous reset, active-high
//  start     input   1     conversion request; sampled only in IDLE or on the final CONV edge
//  cmp       input   1     comparator decision: 1 = held input >= DAC(dac_code), keep trial bit
//  sample    output  1     S/H control: 1 = track, 0 = hold
//  dac_code  output  NBIT  current trial code driving the DAC
//  busy      output  1     high while in SAMPLE or CONV
//  dout      output  NBIT  last completed conversion result; held until the next completion
//  valid     output  1     one-cycle strobe: dout updated this cycle
// BEHAVIOUR
//  - All outputs are registered. Reset values: sample=0, dac_code=0, busy=0, dout=0, valid=0.
//    The FSM resets to IDLE and all counters reset to 0.
//  - States: IDLE -> SAMPLE -> CONV -> (IDLE | SAMPLE). One bit is decided per cycle in CONV.
//  - IDLE: start=1 at edge E0 -> SAMPLE. At that edge sample=1 and busy=1.
//    A sample counter is loaded with SAMPLE_CYC-1.
//  - SAMPLE: the counter decrements each edge. At edge E0+SAMPLE_CYC -> CONV.
//    At that edge: sample=0 (hold), dac_code = 1<<(NBIT-1), bit index i = NBIT-1.
//  - CONV: at each edge, take cmp for bit i.
//      dac_code[i] <= cmp; if i>0 then dac_code[i-1] <= 1 and i <= i-1.
//    Bit i is decided at edge E0+SAMPLE_CYC+(NBIT-i).
//  - Final edge (i=0, edge E0+SAMPLE_CYC+NBIT):
//      dout <= {dac_code[NBIT-1:1], cmp}; valid=1 for exactly one cycle; dac_code <= 0.
//      If start=1: go to SAMPLE (sample=1, busy stays 1; back-to-back operation).
//      Otherwise: go to IDLE and busy=0.
//  - Latency: start edge to valid-high = SAMPLE_CYC+NBIT cycles.
//    Back-to-back period = SAMPLE_CYC+NBIT cycles.
//  - start is ignored in SAMPLE and on all non-final CONV edges. No queuing.
//  - cmp is a don't-care outside CONV.
//  - dac_code is 0 in IDLE and SAMPLE.
//  - rst has priority over every event, including start and the final edge.
//    rst mid-SAMPLE or mid-CONV aborts the conversion: no valid pulse is issued, dout is cleared
//    to 0, and the block is in IDLE the cycle after the rst edge.
//  - sample never glitches. It changes only on posedge clk and is low for the whole CONV phase.
// TESTING (NBIT=8, SAMPLE_CYC=2; bench models cmp = (vhold >= code*LSB), vhold from S/H)
//  1. Assert rst 3 cycles with start=1.
//     -> all outputs 0, busy=0, no valid pulse, sample stays 0.
//  2. start pulse, held input = code 0xA5.
//     -> sample=1 for 2 cycles.
//     -> dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5.
//     -> valid high 10 cycles after the start edge, dout=0xA5, busy falls with valid.
//  3. cmp tied 1, then tied 0.
//     -> dout=0xFF, then dout=0x00; dac_code trial bit walks MSB to LSB.
//  4. start held high, inputs 0x01, 0x80, 0xFE.
//     -> valid every 10 cycles; dout 0x01, 0x80, 0xFE; sample rises on the same edge as valid.
//  5. rst asserted on the 4th CONV edge.
//     -> no valid, dout=0, IDLE next cycle; next conversion of 0x3C gives dout=0x3C.
//  6. Extra start pulses during SAMPLE and mid-CONV.
//     -> ignored: a single valid, timing unchanged.

Source files
------------

// File: rtl/sar_logic.sv
// SAR-ADC controller: tracks for SAMPLE_CYC cycles, then binary-searches one bit per cycle; start-to-valid latency SAMPLE_CYC+NBIT.
// No backpressure: start is only honoured in IDLE or on the final conversion edge, never queued.
module sar_logic #(
  parameter int NBIT       = 8,
  parameter int SAMPLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmp,
  output logic            sample,
  output logic [NBIT-1:0] dac_code,
  output logic            busy,
  output logic [NBIT-1:0] dout,
  output logic            valid
);

  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int BW = $clog2(NBIT);
  localparam logic [NBIT-1:0] MSB_ONLY = {1'b1, {(NBIT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   scnt, scnt_nxt;
  logic [BW-1:0]   bidx, bidx_nxt;
  logic            sample_nxt, busy_nxt, valid_nxt;
  logic [NBIT-1:0] dac_nxt, dout_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scnt     <= '0;
      bidx     <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      dout     <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      scnt     <= scnt_nxt;
      bidx     <= bidx_nxt;
      sample   <= sample_nxt;
      dac_code <= dac_nxt;
      busy     <= busy_nxt;
      dout     <= dout_nxt;
      valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    bidx_nxt   = bidx;
    sample_nxt = sample;
    dac_nxt    = dac_code;
    busy_nxt   = busy;
    dout_nxt   = dout;
    valid_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SAMPLE;
          sample_nxt = 1'b1;
          busy_nxt   = 1'b1;
          scnt_nxt   = SW'(SAMPLE_CYC - 1);
          dac_nxt    = '0;
        end
      end
      SAMPLE: begin
        if (scnt == '0) begin
          state_nxt  = CONV;
          sample_nxt = 1'b0;
          dac_nxt    = MSB_ONLY;
          bidx_nxt   = BW'(NBIT - 1);
        end else begin
          scnt_nxt = scnt - 1'b1;
        end
      end
      CONV: begin
        dac_nxt[bidx] = cmp;
        if (bidx != '0) begin
          dac_nxt[bidx - 1'b1] = 1'b1;
          bidx_nxt             = bidx - 1'b1;
        end else begin
          // Last bit goes straight to dout; the DAC is parked at zero.
          dout_nxt  = {dac_code[NBIT-1:1], cmp};
          valid_nxt = 1'b1;
          dac_nxt   = '0;
          if (start) begin
            state_nxt  = SAMPLE;
            sample_nxt = 1'b1;
            scnt_nxt   = SW'(SAMPLE_CYC - 1);
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
